// File: rtl/msg_scroll_pkg.sv
// rtl/msg_scroll_pkg.sv - character codes and 14-segment encoder for the scrolling message source
package msg_scroll_pkg;

  localparam int CH_W  = 6;
  localparam int SEG_W = 14;

  localparam logic [CH_W-1:0] CH_SPACE = 6'd0;
  localparam logic [CH_W-1:0] CH_A = 6'd1,  CH_B = 6'd2,  CH_C = 6'd3,  CH_D = 6'd4,
                              CH_E = 6'd5,  CH_F = 6'd6,  CH_G = 6'd7,  CH_H = 6'd8,
                              CH_I = 6'd9,  CH_J = 6'd10, CH_K = 6'd11, CH_L = 6'd12,
                              CH_M = 6'd13, CH_N = 6'd14, CH_O = 6'd15, CH_P = 6'd16,
                              CH_Q = 6'd17, CH_R = 6'd18, CH_S = 6'd19, CH_T = 6'd20,
                              CH_U = 6'd21, CH_V = 6'd22, CH_W_ = 6'd23, CH_X = 6'd24,
                              CH_Y = 6'd25, CH_Z = 6'd26;
  localparam logic [CH_W-1:0] CH_NN = 6'd27;
  localparam logic [CH_W-1:0] CH_D0 = 6'd28, CH_D1 = 6'd29, CH_D2 = 6'd30, CH_D3 = 6'd31,
                              CH_D4 = 6'd32, CH_D5 = 6'd33, CH_D6 = 6'd34, CH_D7 = 6'd35,
                              CH_D8 = 6'd36, CH_D9 = 6'd37;

  // Bit 13 = a, 12 = b, 11 = c, 10 = d, 9 = e, 8 = f, 7 = g1, 6 = g2,
  // 5 = h, 4 = i, 3 = j, 2 = k, 1 = l, 0 = m. Unused codes render blank.
  function automatic logic [SEG_W-1:0] seg_enc(input logic [CH_W-1:0] code);
    case (code)
      CH_A:  return 14'h3BC0;
      CH_B:  return 14'h3C52;
      CH_C:  return 14'h2700;
      CH_D:  return 14'h3C12;
      CH_E:  return 14'h2780;
      CH_F:  return 14'h2380;
      CH_G:  return 14'h2F40;
      CH_H:  return 14'h1BC0;
      CH_I:  return 14'h2412;
      CH_J:  return 14'h1E00;
      CH_K:  return 14'h0389;
      CH_L:  return 14'h0700;
      CH_M:  return 14'h1B28;
      CH_N:  return 14'h1B21;
      CH_O:  return 14'h3F00;
      CH_P:  return 14'h33C0;
      CH_Q:  return 14'h3F01;
      CH_R:  return 14'h33C1;
      CH_S:  return 14'h2DC0;
      CH_T:  return 14'h2012;
      CH_U:  return 14'h1F00;
      CH_V:  return 14'h030C;
      CH_W_: return 14'h1B05;
      CH_X:  return 14'h002D;
      CH_Y:  return 14'h002A;
      CH_Z:  return 14'h240C;
      CH_NN: return 14'h3B21;
      CH_D0: return 14'h3F0C;
      CH_D1: return 14'h1808;
      CH_D2: return 14'h36C0;
      CH_D3: return 14'h3C40;
      CH_D4: return 14'h19C0;
      CH_D5: return 14'h2DC0;
      CH_D6: return 14'h2FC0;
      CH_D7: return 14'h3800;
      CH_D8: return 14'h3FC0;
      CH_D9: return 14'h3DC0;
      default: return 14'h0000;
    endcase
  endfunction

endpackage

// File: rtl/msg_scroll_src_tick.sv
// rtl/msg_scroll_src_tick.sv - scroll prescaler with a sticky pending-step flag
module scroll_tick #(
  parameter int DIV = 12000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic ack,
  output logic pending
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == CW'(DIV - 1));

  // Count enabled cycles; an expiry latches pending until the commit acknowledges it.
  // A fresh expiry in the acknowledge cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + CW'(1);
      pending <= tick || (pending && !ack);
    end
  end

endmodule

// File: rtl/msg_scroll_src.sv
// rtl/msg_scroll_src.sv - message buffer, scroll offset and per-digit segment lookup
module msg_scroll_src
  import msg_scroll_pkg::*;
#(
  parameter int MAX_LEN    = 32,
  parameter int SCROLL_DIV = 12000000,
  parameter int NUM_DIG    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [5:0]  wr_char,
  input  logic        len_we,
  input  logic [5:0]  len_in,
  input  logic        scroll_en,
  input  logic [3:0]  dig_idx,
  output logic [13:0] seg,
  output logic        wrap
);

  localparam int          AW      = $clog2(MAX_LEN);
  localparam logic [5:0]  LEN_MAX = 6'(MAX_LEN);

  logic [CH_W-1:0] mem [MAX_LEN];
  logic [5:0]      msg_len;
  logic [5:0]      offset;
  logic            pending;
  logic            commit;
  logic            blank;
  logic [6:0]      period;
  logic [6:0]      p_raw;
  logic [6:0]      p_fold;
  logic [6:0]      off_inc;

  // Position in the virtual stream (message + NUM_DIG blanks) for the scanned digit.
  always_comb begin
    period  = 7'(msg_len) + 7'(NUM_DIG);
    p_raw   = 7'(offset) + 7'(dig_idx);
    p_fold  = (p_raw >= period) ? p_raw - period : p_raw;
    off_inc = 7'(offset) + 7'd1;
    commit  = pending && (dig_idx == 4'(NUM_DIG - 1)) && !len_we;
    blank   = (dig_idx >= 4'(NUM_DIG)) || (p_fold >= 7'(msg_len)) || (msg_len == 6'd0);
  end

  scroll_tick #(.DIV(SCROLL_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (scroll_en && (msg_len != 6'd0)),
    .clr     (len_we),
    .ack     (commit),
    .pending (pending)
  );

  // Character buffer; reads below see the pre-write contents in a collision cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= CH_SPACE;
    end else if (wr_en) begin
      mem[wr_addr[AW-1:0]] <= wr_char;
    end
  end

  // Length load restarts the scroll; otherwise steps are applied only at the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_len <= '0;
      offset  <= '0;
      wrap    <= 1'b0;
    end else if (len_we) begin
      msg_len <= (len_in > LEN_MAX) ? LEN_MAX : len_in;
      offset  <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= commit && (off_inc == period);
      if (commit) offset <= (off_inc == period) ? 6'd0 : off_inc[5:0];
    end
  end

  // Registered segment lookup for the scanned digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seg <= '0;
    else     seg <= blank ? 14'h0000 : seg_enc(mem[p_fold[AW-1:0]]);
  end

endmodule

// File: tb/tb_msg_scroll_src.sv
// tb/tb_msg_scroll_src.sv - randomized self-checking bench for msg_scroll_src
module tb_msg_scroll_src;

  localparam int DIV  = 4;
  localparam int NDIG = 12;
  localparam int MLEN = 32;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [5:0]  wr_char;
  logic        len_we;
  logic [5:0]  len_in;
  logic        scroll_en;
  logic [3:0]  dig_idx;
  logic [13:0] seg;
  logic        wrap;

  msg_scroll_src #(.MAX_LEN(MLEN), .SCROLL_DIV(DIV), .NUM_DIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .len_we    (len_we),
    .len_in    (len_in),
    .scroll_en (scroll_en),
    .dig_idx   (dig_idx),
    .seg       (seg),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: message array, length, offset, enabled-cycle count, pending flag.
  int          m_buf[MLEN];
  int          m_len, m_off, m_cnt;
  bit          m_pend;
  logic [13:0] e_seg;
  bit          e_wrap;

  int          msg[7]        = '{3, 1, 13, 1, 3, 8, 15};
  logic [13:0] static_tab[12] = '{14'h2700, 14'h3BC0, 14'h1B28, 14'h3BC0, 14'h2700, 14'h1BC0,
                                  14'h3F00, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0000};
  int          allowed[6]    = '{0, 1, 3, 8, 13, 15};

  function automatic void model_reset();
    for (int i = 0; i < MLEN; i++) m_buf[i] = 0;
    m_len = 0; m_off = 0; m_cnt = 0; m_pend = 0; e_wrap = 0;
  endfunction

  function automatic logic [13:0] ref_enc(input int code);
    case (code)
      0:  return 14'h0000;
      1:  return 14'h3BC0;
      3:  return 14'h2700;
      8:  return 14'h1BC0;
      13: return 14'h1B28;
      15: return 14'h3F00;
      default: return (code >= 38) ? 14'h0000 : 14'h3FFF;
    endcase
  endfunction

  function automatic logic [13:0] ref_view(input int dig);
    int pos;
    if (dig >= NDIG || m_len == 0) return 14'h0000;
    pos = (m_off + dig) % (m_len + NDIG);
    return (pos < m_len) ? ref_enc(m_buf[pos]) : 14'h0000;
  endfunction

  // One clock edge: predict from pre-edge state, advance the model, compare outputs.
  task automatic step(input string tag);
    bit en, commit, tick;
    e_seg  = ref_view(int'(dig_idx));
    en     = scroll_en && (m_len != 0);
    commit = !len_we && m_pend && (int'(dig_idx) == NDIG - 1);
    tick   = en && ((m_cnt + 1) % DIV == 0);
    @(posedge clk);
    #1;
    if (len_we) begin
      m_len  = (int'(len_in) > MLEN) ? MLEN : int'(len_in);
      m_off  = 0; m_cnt = 0; m_pend = 0; e_wrap = 0;
    end else begin
      e_wrap = 0;
      if (en) m_cnt++;
      if (commit) begin
        m_off  = (m_off + 1) % (m_len + NDIG);
        e_wrap = (m_off == 0);
      end
      m_pend = tick || (m_pend && !commit);
    end
    if (wr_en) m_buf[int'(wr_addr) % MLEN] = int'(wr_char);
    chk({tag, "_seg"}, 32'(seg), 32'(e_seg));
    chk({tag, "_wrap"}, 32'(wrap), 32'(e_wrap));
  endtask

  task automatic write_msg();
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_char = 6'(msg[i]);
      step("wr");
    end
    wr_en = 1'b0;
  endtask

  task automatic load_len(input int n);
    len_we = 1'b1; len_in = 6'(n);
    step("len");
    len_we = 1'b0;
  endtask

  int wraps;
  int sc;
  int oor[3] = '{12, 13, 15};

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_char = '0; len_we = 1'b0; len_in = '0;
    scroll_en = 1'b0; dig_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_seg", 32'(seg), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    rst = 1'b0;

    // Static text
    write_msg();
    load_len(7);
    for (int d = 0; d < NDIG; d++) begin
      dig_idx = 4'(d); step("static");
      chk("static_const", 32'(seg), 32'(static_tab[d]));
    end
    foreach (oor[i]) begin
      dig_idx = 4'(oor[i]); step("oor");
      chk("oor_const", 32'(seg), 32'h0);
    end

    // Short message holding 'O'
    wr_en = 1'b1; wr_addr = 5'd0; wr_char = 6'd15; step("wr_o"); wr_en = 1'b0;
    load_len(1);
    for (int d = 0; d < 16; d++) begin
      dig_idx = 4'(d); step("short");
      chk("short_const", 32'(seg), (d == 0) ? 32'h3F00 : 32'h0);
    end
    write_msg();

    // Scroll and wrap
    load_len(7);
    scroll_en = 1'b1; wraps = 0;
    for (int s = 0; s < 20; s++) begin
      for (int d = 0; d < NDIG; d++) begin
        dig_idx = 4'(d); step("scroll");
        wraps += int'(wrap);
        if (s == 1 && d == 0)   chk("scroll_first_A", 32'(seg), 32'h3BC0);
        if (s == 18 && d == 11) chk("wrap_at_19", 32'(wrap), 32'h1);
      end
    end
    chk("wrap_count", 32'(wraps), 32'h1);

    // Length reload colliding with a pending commit at the last digit
    for (int d = 0; d < NDIG; d++) begin
      dig_idx = 4'(d);
      if (d == NDIG - 1) begin len_we = 1'b1; len_in = 6'd40; end
      step("reload");
      len_we = 1'b0;
    end
    chk("reload_wrap", 32'(wrap), 32'h0);
    scroll_en = 1'b0;
    for (int d = 0; d < NDIG; d++) begin
      dig_idx = 4'(d); step("reload_view");
      chk("reload_view_const", 32'(seg), 32'(static_tab[d]));
    end

    // Read/write collision with an invalid code
    load_len(7);
    dig_idx = 4'd2; wr_en = 1'b1; wr_addr = 5'd2; wr_char = 6'd50;
    step("coll");
    chk("coll_old", 32'(seg), 32'h1B28);
    wr_en = 1'b0;
    step("coll2");
    chk("coll_new", 32'(seg), 32'h0);

    // Randomized traffic
    sc = 0;
    for (int n = 0; n < 3000; n++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 5'($urandom);
      wr_char = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(38, 63))
                                            : 6'(allowed[$urandom_range(0, 5)]);
      len_we  = ($urandom_range(0, 59) == 0);
      len_in  = 6'($urandom);
      scroll_en = ($urandom_range(0, 7) != 0);
      dig_idx = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'(sc);
      sc = (sc + 1) % NDIG;
      step("rand");
    end
    wr_en = 1'b0; len_we = 1'b0;

    // Async reset mid-scroll at offset 5
    write_msg();
    load_len(7);
    scroll_en = 1'b1;
    for (int s = 0; s < 5; s++)
      for (int d = 0; d < NDIG; d++) begin
        dig_idx = 4'(d); step("pre_rst");
      end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_seg", 32'(seg), 32'h0);
    chk("arst_wrap", 32'(wrap), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; scroll_en = 1'b0;
    load_len(7);
    for (int d = 0; d < NDIG; d++) begin
      dig_idx = 4'(d); step("post_rst");
      chk("post_rst_blank", 32'(seg), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
